stage_decode: RTL

- Pipeline stage directly downstream of instruction fetch in the brainfuck CPU. Consumes raw 8-bit opcodes via the drdy/ack handshake.
- Drops comment characters. Merges runs of '+'/'-' and '<'/'>' into signed deltas. Hands one micro-op at a time to the execute stage through a valid/ack register slice.

---
 rtl/bf_pkg.sv | 25 ++
 rtl/bf_opcode_classify.sv | 46 ++++
 rtl/stage_decode.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared types and opcode constants for the brainfuck CPU pipeline.
// Micro-op kinds and ASCII opcode values used by decode and execute.
package bf_pkg;

  typedef enum logic [2:0] {
    K_DATA = 3'd0,
    K_PTR  = 3'd1,
    K_JZ   = 3'd2,
    K_JNZ  = 3'd3,
    K_OUT  = 3'd4,
    K_IN   = 3'd5,
    K_HALT = 3'd6
  } op_kind_t;

  localparam logic [7:0] OPC_INC   = 8'h2B;
  localparam logic [7:0] OPC_DEC   = 8'h2D;
  localparam logic [7:0] OPC_RIGHT = 8'h3E;
  localparam logic [7:0] OPC_LEFT  = 8'h3C;
  localparam logic [7:0] OPC_JZ    = 8'h5B;
  localparam logic [7:0] OPC_JNZ   = 8'h5D;
  localparam logic [7:0] OPC_OUT   = 8'h2E;
  localparam logic [7:0] OPC_IN    = 8'h2C;
  localparam logic [7:0] OPC_HALT  = 8'h00;

endpackage

// File: rtl/bf_opcode_classify.sv
// Combinational opcode classifier: command flag, kind, step sign and
// whether the opcode belongs to a mergeable arithmetic class.
module bf_opcode_classify
  import bf_pkg::*;
#(
  parameter int D_WIDTH = 8
) (
  input  logic [D_WIDTH-1:0] i_opcode,
  output logic               o_is_cmd,
  output op_kind_t           o_kind,
  output logic               o_neg,
  output logic               o_coal
);

  always_comb begin
    o_is_cmd = 1'b1;
    o_kind   = K_DATA;
    o_neg    = 1'b0;
    o_coal   = 1'b0;
    unique case (1'b1)
      (i_opcode == D_WIDTH'(OPC_INC)): begin
        o_coal = 1'b1;
      end
      (i_opcode == D_WIDTH'(OPC_DEC)): begin
        o_coal = 1'b1;
        o_neg  = 1'b1;
      end
      (i_opcode == D_WIDTH'(OPC_RIGHT)): begin
        o_kind = K_PTR;
        o_coal = 1'b1;
      end
      (i_opcode == D_WIDTH'(OPC_LEFT)): begin
        o_kind = K_PTR;
        o_coal = 1'b1;
        o_neg  = 1'b1;
      end
      (i_opcode == D_WIDTH'(OPC_JZ)):   o_kind = K_JZ;
      (i_opcode == D_WIDTH'(OPC_JNZ)):  o_kind = K_JNZ;
      (i_opcode == D_WIDTH'(OPC_OUT)):  o_kind = K_OUT;
      (i_opcode == D_WIDTH'(OPC_IN)):   o_kind = K_IN;
      (i_opcode == D_WIDTH'(OPC_HALT)): o_kind = K_HALT;
      default: o_is_cmd = 1'b0;
    endcase
  end

endmodule

// File: rtl/stage_decode.sv
// Decode stage: drops comments, merges +/- and </> runs into deltas.
// Run merging is built only when DECODE_COALESCE_EN is defined.
module stage_decode
  import bf_pkg::*;
#(
  parameter int D_WIDTH   = 8,
  parameter int ARG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [D_WIDTH-1:0]   opcode,
  input  logic                 drdy_in,
  output logic                 ack_out,
  output logic                 op_valid,
  output logic [2:0]           op_kind,
  output logic [ARG_WIDTH-1:0] op_arg,
  input  logic                 op_ack,
  output logic                 halted
);

  localparam logic [ARG_WIDTH-1:0] ARG_ONE = ARG_WIDTH'(1);
  localparam logic [ARG_WIDTH-1:0] ARG_NEG = '1;

  logic                 r_acc_v;
  logic                 r_acc_c;
  op_kind_t             r_acc_k;
  logic [ARG_WIDTH-1:0] r_acc_a;
  logic                 r_out_v;
  op_kind_t             r_out_k;
  logic [ARG_WIDTH-1:0] r_out_a;
  logic                 r_halted;

  logic                 w_cmd;
  op_kind_t             w_kind;
  logic                 w_neg;
  logic                 w_coal;
  logic [ARG_WIDTH-1:0] w_step;
  logic                 w_free;
  logic                 w_merge;
  logic                 w_closing;
  logic                 w_ld_closed;
  logic                 w_vacate;
  logic                 w_accept;
  logic                 w_load;

  bf_opcode_classify #(
    .D_WIDTH (D_WIDTH)
  ) u_cls (
    .i_opcode (opcode),
    .o_is_cmd (w_cmd),
    .o_kind   (w_kind),
    .o_neg    (w_neg),
    .o_coal   (w_coal)
  );

  assign w_free = !r_out_v || op_ack;
  assign w_step = w_neg ? ARG_NEG : ARG_ONE;

`ifdef DECODE_COALESCE_EN
  localparam logic [ARG_WIDTH-1:0] ARG_MAX =
    {1'b0, {(ARG_WIDTH-1){1'b1}}};
  localparam logic [ARG_WIDTH-1:0] ARG_MIN =
    {1'b1, {(ARG_WIDTH-1){1'b0}}};

  logic w_open;
  logic w_same;
  logic w_ovf;

  assign w_open = r_acc_v && !r_acc_c;
  assign w_same = w_cmd && w_coal && (w_kind == r_acc_k);
  assign w_ovf  = w_neg ? (r_acc_a == ARG_MIN)
                        : (r_acc_a == ARG_MAX);
  assign w_merge = w_open && drdy_in && w_same && !w_ovf;
  // An idle cycle flushes an open run so execute never starves.
  assign w_closing = w_open &&
    (!drdy_in || (w_cmd && (!w_same || w_ovf)));
  assign w_ld_closed = !w_coal;
`else
  assign w_merge     = 1'b0;
  assign w_closing   = 1'b0;
  assign w_ld_closed = 1'b1;
`endif

  assign w_vacate = r_acc_v && (r_acc_c || w_closing) && w_free;
  assign w_accept = !w_cmd || !r_acc_v || w_merge || w_vacate;
  assign ack_out  = reset_n && drdy_in && !r_halted && w_accept;
  assign w_load   = ack_out && w_cmd && !w_merge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_v  <= 1'b0;
      r_acc_c  <= 1'b0;
      r_acc_k  <= K_DATA;
      r_acc_a  <= '0;
      r_out_v  <= 1'b0;
      r_out_k  <= K_DATA;
      r_out_a  <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_free) begin
        r_out_v <= w_vacate;
        if (w_vacate) begin
          r_out_k <= r_acc_k;
          r_out_a <= r_acc_a;
        end
      end
      if (w_load) begin
        r_acc_v <= 1'b1;
        r_acc_c <= w_ld_closed;
        r_acc_k <= w_kind;
        r_acc_a <= w_coal ? w_step : '0;
      end else if (ack_out && w_merge) begin
        r_acc_a <= r_acc_a + w_step;
      end else if (w_vacate) begin
        r_acc_v <= 1'b0;
      end else if (w_closing) begin
        r_acc_c <= 1'b1;
      end
      if (w_load && (w_kind == K_HALT)) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign op_valid = r_out_v;
  assign op_kind  = r_out_k;
  assign op_arg   = r_out_a;
  assign halted   = r_halted;

endmodule
